dma: RTL and testbench

DMA -- requirements
Module: dma

---
 rtl/global_pkg.sv | 33 +++
 rtl/dma_tx.sv | 90 +++++++++
 rtl/dma.sv | 134 +++++++++++++
 tb/tb_dma.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_pkg.sv
// global_pkg -- shared constants and state encoding for the DMA block.
//   DMA_RX_BASE       : first RAM address of the 3-byte receive ring
//   DMA_TX_BASE       : first RAM address of the transmit buffer
//   DMA_NEW_INST_ADDR : RAM address of the "new instruction" flag byte
//   DMA_TX_LEN        : number of bytes sent per TX command
//   dma_state_t       : controller state encoding (shared by dma and dma_tx)
package global_pkg;

  localparam logic [7:0] DMA_RX_BASE       = 8'h00;
  localparam logic [7:0] DMA_TX_BASE       = 8'h04;
  localparam logic [7:0] DMA_NEW_INST_ADDR = 8'h03;
  localparam logic [7:0] DMA_NEW_INST_VAL  = 8'hFF;
  localparam int         DMA_TX_LEN        = 2;

  // Width of the TX byte index; at least one bit even for a 1-byte buffer.
  localparam int TX_IDX_W = (DMA_TX_LEN > 1) ? $clog2(DMA_TX_LEN) : 1;

  // Receive ring holds three bytes: rx_cnt runs 0,1,2 then wraps.
  localparam logic [1:0] RX_CNT_LAST = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    RX_REQ,
    RX_WRITE,
    RX_FLAG,
    RX_RELEASE,
    TX_READ,
    TX_CAPTURE,
    TX_SEND,
    TX_DONE
  } dma_state_t;

endpackage

// File: rtl/dma_tx.sv
// dma_tx -- transmit path of the DMA: reads DMA_TX_LEN bytes from RAM starting
// at DMA_TX_BASE and hands each one to the transmitter with a valid/ready
// handshake, then pulses DMA_Ready.
// The state register lives in the parent; this block decodes the TX states,
// proposes the next state and owns the byte index and the TX data register.
// Ports:
//   Clk, Rst   : clock, synchronous active-high reset
//   state      : current controller state (from dma)
//   tx_next    : proposed next state while in a TX state
//   TX_Ready   : transmitter accepts the byte
//   DataIn     : RAM read data (one cycle after the read strobe)
//   ram_cs/ram_oen/ram_addr : RAM read strobe and address (0 when idle)
//   TX_Data/TX_Valid        : byte to transmitter and its valid
//   DMA_Ready  : one-cycle completion pulse to the CPU
module dma_tx
  import global_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  dma_state_t state,
  input  logic       TX_Ready,
  input  logic [7:0] DataIn,
  output dma_state_t tx_next,
  output logic       ram_cs,
  output logic       ram_oen,
  output logic [7:0] ram_addr,
  output logic [7:0] TX_Data,
  output logic       TX_Valid,
  output logic       DMA_Ready
);

  logic [TX_IDX_W-1:0] tx_idx_reg, tx_idx_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic                tx_last;

  assign tx_last = (tx_idx_reg == TX_IDX_W'(DMA_TX_LEN - 1));
  assign TX_Data = tx_data_reg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tx_idx_reg  <= '0;
      tx_data_reg <= 8'h00;
    end else begin
      tx_idx_reg  <= tx_idx_next;
      tx_data_reg <= tx_data_next;
    end
  end

  always_comb begin
    tx_next      = state;
    ram_cs       = 1'b0;
    ram_oen      = 1'b0;
    ram_addr     = 8'h00;
    TX_Valid     = 1'b0;
    DMA_Ready    = 1'b0;
    tx_idx_next  = tx_idx_reg;
    tx_data_next = tx_data_reg;
    case (state)
      TX_READ: begin
        ram_cs   = 1'b1;
        ram_oen  = 1'b1;
        ram_addr = DMA_TX_BASE + 8'(tx_idx_reg);
        tx_next  = TX_CAPTURE;
      end
      TX_CAPTURE: begin
        // RAM has one cycle of read latency: the byte is on DataIn now.
        tx_data_next = DataIn;
        tx_next      = TX_SEND;
      end
      TX_SEND: begin
        TX_Valid = 1'b1;
        if (TX_Ready) begin
          if (tx_last) begin
            tx_idx_next = '0;
            tx_next     = TX_DONE;
          end else begin
            tx_idx_next = tx_idx_reg + TX_IDX_W'(1);
            tx_next     = TX_READ;
          end
        end
      end
      TX_DONE: begin
        DMA_Ready = 1'b1;
        tx_next   = IDLE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dma.sv
// dma -- byte DMA between a receiver FIFO, a transmitter and a shared RAM.
// RX: each FIFO byte is moved into a 3-byte ring at DMA_RX_BASE under a CPU
// bus grant (DMA_Req/DMA_Ack), one byte per grant. TX: on DMA_Tx_Start the
// dma_tx sub-block streams DMA_TX_LEN bytes from DMA_TX_BASE to the
// transmitter. TX wins when both are pending.
// Optional feature (macro DMA_NEW_INST_EN): after the third ring byte, write
// 8'hFF to DMA_NEW_INST_ADDR before releasing the bus.
// Ports:
//   Clk, Rst                     : clock, synchronous active-high reset
//   RX_Data, RX_Empty, RX_Read   : receiver FIFO head, empty flag, pop
//   TX_Data, TX_Valid, TX_Ready  : transmitter byte handshake
//   DMA_Req, DMA_Ack             : bus request / grant with the CPU
//   DMA_Tx_Start, DMA_Ready      : CPU TX command / completion pulse
//   RAM_Addr, RAM_Cs, RAM_Wen, RAM_Oen, DataOut, DataIn : RAM port
module dma
  import global_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] RX_Data,
  input  logic       RX_Empty,
  output logic       RX_Read,
  output logic [7:0] TX_Data,
  output logic       TX_Valid,
  input  logic       TX_Ready,
  output logic       DMA_Req,
  input  logic       DMA_Ack,
  input  logic       DMA_Tx_Start,
  output logic       DMA_Ready,
  output logic [7:0] RAM_Addr,
  output logic       RAM_Cs,
  output logic       RAM_Wen,
  output logic       RAM_Oen,
  output logic [7:0] DataOut,
  input  logic [7:0] DataIn
);

  dma_state_t state_reg, state_next, tx_next;
  logic [1:0] rx_cnt_reg, rx_cnt_next;
  logic       tx_block_reg;
  logic       tx_ram_cs, tx_ram_oen;
  logic [7:0] tx_ram_addr;

  dma_tx u_tx (
    .Clk       (Clk),
    .Rst       (Rst),
    .state     (state_reg),
    .TX_Ready  (TX_Ready),
    .DataIn    (DataIn),
    .tx_next   (tx_next),
    .ram_cs    (tx_ram_cs),
    .ram_oen   (tx_ram_oen),
    .ram_addr  (tx_ram_addr),
    .TX_Data   (TX_Data),
    .TX_Valid  (TX_Valid),
    .DMA_Ready (DMA_Ready)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg    <= IDLE;
      rx_cnt_reg   <= 2'd0;
      tx_block_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rx_cnt_reg   <= rx_cnt_next;
      // The CPU may still be holding DMA_Tx_Start the cycle after
      // DMA_Ready; ignore it for that one cycle so TX does not rerun.
      tx_block_reg <= (state_reg == TX_DONE);
    end
  end

  always_comb begin
    state_next  = state_reg;
    rx_cnt_next = rx_cnt_reg;
    RX_Read     = 1'b0;
    DMA_Req     = 1'b0;
    RAM_Cs      = tx_ram_cs;
    RAM_Oen     = tx_ram_oen;
    RAM_Addr    = tx_ram_addr;
    RAM_Wen     = 1'b0;
    DataOut     = 8'h00;
    case (state_reg)
      // RX_RELEASE arbitrates like IDLE so a waiting FIFO byte gets a new
      // request in the very next cycle; the request line is low here,
      // which closes the previous grant session.
      IDLE, RX_RELEASE: begin
        if (DMA_Tx_Start && !tx_block_reg)
          state_next = TX_READ;
        else if (!RX_Empty)
          state_next = RX_REQ;
        else
          state_next = IDLE;
      end
      RX_REQ: begin
        DMA_Req = 1'b1;
        if (DMA_Ack)
          state_next = RX_WRITE;
      end
      RX_WRITE: begin
        DMA_Req  = 1'b1;
        RAM_Cs   = 1'b1;
        RAM_Wen  = 1'b1;
        RAM_Addr = DMA_RX_BASE + {6'b0, rx_cnt_reg};
        DataOut  = RX_Data;
        RX_Read  = 1'b1;
        if (rx_cnt_reg == RX_CNT_LAST) begin
          rx_cnt_next = 2'd0;
`ifdef DMA_NEW_INST_EN
          state_next  = RX_FLAG;
`else
          state_next  = RX_RELEASE;
`endif
        end else begin
          rx_cnt_next = rx_cnt_reg + 2'd1;
          state_next  = RX_RELEASE;
        end
      end
`ifdef DMA_NEW_INST_EN
      RX_FLAG: begin
        DMA_Req    = 1'b1;
        RAM_Cs     = 1'b1;
        RAM_Wen    = 1'b1;
        RAM_Addr   = DMA_NEW_INST_ADDR;
        DataOut    = DMA_NEW_INST_VAL;
        state_next = RX_RELEASE;
      end
`endif
      TX_READ, TX_CAPTURE, TX_SEND, TX_DONE: state_next = tx_next;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma.sv
// tb_dma -- self-checking bench for dma. Behavioural FIFO, RAM, bus-grant and
// transmitter models surround the DUT; stimulus pushes expected RAM writes
// and TX bytes into queues, and a monitor compares every observed write and
// TX handshake against them. One line is printed per transaction.
module tb_dma;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] RX_Data = 8'h00;
  logic       RX_Empty = 1'b1;
  logic       RX_Read;
  logic [7:0] TX_Data;
  logic       TX_Valid;
  logic       TX_Ready = 1'b0;
  logic       DMA_Req;
  logic       DMA_Ack = 1'b0;
  logic       DMA_Tx_Start = 1'b0;
  logic       DMA_Ready;
  logic [7:0] RAM_Addr;
  logic       RAM_Cs, RAM_Wen, RAM_Oen;
  logic [7:0] DataOut;
  logic [7:0] DataIn = 8'h00;

  always #5 Clk = ~Clk;

  dma dut (
    .Clk(Clk), .Rst(Rst),
    .RX_Data(RX_Data), .RX_Empty(RX_Empty), .RX_Read(RX_Read),
    .TX_Data(TX_Data), .TX_Valid(TX_Valid), .TX_Ready(TX_Ready),
    .DMA_Req(DMA_Req), .DMA_Ack(DMA_Ack),
    .DMA_Tx_Start(DMA_Tx_Start), .DMA_Ready(DMA_Ready),
    .RAM_Addr(RAM_Addr), .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen),
    .DataOut(DataOut), .DataIn(DataIn)
  );

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         rx_read_cnt = 0;
  int         ready_cnt = 0;
  int         stall_len = 0;
  int         stall_cnt = 0;
  int         req_cyc = 0;
  bit         ack_en = 1'b1;
  bit         hold_chk_en = 1'b1;
  bit         hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] mem [256];
  logic [7:0] fifo [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_tx [$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [31:0] outs_all();
    return 32'({RX_Read, TX_Valid, TX_Data, DMA_Req, DMA_Ready,
                RAM_Addr, RAM_Cs, RAM_Wen, RAM_Oen, DataOut});
  endfunction

  function automatic void expect_wr(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
`ifdef DMA_NEW_INST_EN
    if (a == 8'h02) exp_wr.push_back({8'h03, 8'hFF});
`endif
  endfunction

  // RAM model: synchronous write, registered read (one-cycle latency).
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[4] = 8'h12;
    mem[5] = 8'h34;
    forever begin
      @(posedge Clk);
      if (RAM_Cs && RAM_Wen) mem[RAM_Addr] = DataOut;
      if (RAM_Cs && RAM_Oen) DataIn = mem[RAM_Addr];
    end
  end

  // Receiver FIFO model: pop on RX_Read, head/empty refreshed away from edges.
  initial begin
    forever begin
      @(posedge Clk);
      if (RX_Read) begin
        rx_read_cnt++;
        if (fifo.size() > 0) void'(fifo.pop_front());
      end
      #1;
      RX_Empty = (fifo.size() == 0);
      RX_Data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
      @(negedge Clk);
      #3;
      RX_Empty = (fifo.size() == 0);
      RX_Data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  // CPU grant model: acknowledge on the second cycle of a request.
  initial begin
    forever begin
      @(negedge Clk);
      if (DMA_Req && ack_en) req_cyc++;
      else req_cyc = 0;
      DMA_Ack = (req_cyc >= 2);
    end
  end

  // Transmitter model: stall stall_len cycles per byte, then accept.
  initial begin
    forever begin
      @(negedge Clk);
      if (TX_Valid) begin
        if (stall_cnt >= stall_len) TX_Ready = 1'b1;
        else begin
          TX_Ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        TX_Ready  = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [15:0] ew;
    logic [7:0]  et;
    forever begin
      @(negedge Clk);
      #1;
      if (RAM_Cs && RAM_Wen) begin
        ew = (exp_wr.size() > 0) ? exp_wr.pop_front() : ~{RAM_Addr, DataOut};
        $display("ram write addr=%02h data=%02h", RAM_Addr, DataOut);
        check("ram_wr", 32'({RAM_Addr, DataOut}), 32'(ew));
      end
      if (hold_prev && hold_chk_en)
        check("tx_hold", 32'({TX_Valid, TX_Data}), 32'({1'b1, prev_data}));
      if (TX_Valid && TX_Ready) begin
        et = (exp_tx.size() > 0) ? exp_tx.pop_front() : ~TX_Data;
        $display("tx byte data=%02h", TX_Data);
        check("tx_byte", 32'(TX_Data), 32'(et));
      end
      hold_prev = hold_chk_en && TX_Valid && !TX_Ready;
      prev_data = TX_Data;
      if (DMA_Ready) begin
        ready_cnt++;
        $display("dma ready pulse #%0d", ready_cnt);
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int quiet = 0;
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk);
      #1;
      if (RX_Empty && !DMA_Req && !RAM_Cs && !TX_Valid && !DMA_Ready) quiet++;
      else quiet = 0;
      if (quiet >= 4) done = 1'b1;
    end
    check({name, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic wait_ready(input string name, input int budget, output bit req_seen);
    bit got = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge Clk);
      #1;
      if (DMA_Req) req_seen = 1'b1;
      if (DMA_Ready) got = 1'b1;
    end
    check({name, "_ready_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_signal_req(input string name, input int budget, input bit want_valid);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge Clk);
      #1;
      if (want_valid ? TX_Valid : DMA_Req) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  initial begin
    bit req_seen;
    // Reset state.
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    check("reset_outputs", outs_all(), 32'd0);
    Rst = 1'b0;

    // Three RX bytes into the ring.
    expect_wr(8'h00, 8'h4C);
    expect_wr(8'h01, 8'h41);
    expect_wr(8'h02, 8'h31);
    @(negedge Clk);
    fifo.push_back(8'h4C);
    fifo.push_back(8'h41);
    fifo.push_back(8'h31);
    wait_idle("rx3", 200);
    check("rx3_reads", 32'(rx_read_cnt), 32'd3);
    check("ram0", 32'(mem[0]), 32'h4C);
    check("ram1", 32'(mem[1]), 32'h41);
    check("ram2", 32'(mem[2]), 32'h31);
`ifdef DMA_NEW_INST_EN
    check("ram3_flag", 32'(mem[3]), 32'hFF);
`else
    check("ram3_flag", 32'(mem[3]), 32'h00);
`endif

    // TX of two bytes with 5-cycle stalls; Tx_Start held one cycle late.
    stall_len = 5;
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    @(negedge Clk);
    DMA_Tx_Start = 1'b1;
    wait_ready("tx", 300, req_seen);
    check("tx_no_req", 32'(req_seen), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    DMA_Tx_Start = 1'b0;
    wait_idle("tx", 50);
    check("tx_ready_pulses", 32'(ready_cnt), 32'd1);

    // TX and RX pending together: TX first, then the RX byte.
    stall_len = 2;
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    expect_wr(8'h00, 8'hAA);
    @(negedge Clk);
    DMA_Tx_Start = 1'b1;
    fifo.push_back(8'hAA);
    wait_ready("prio", 300, req_seen);
    DMA_Tx_Start = 1'b0;
    check("prio_no_req", 32'(req_seen), 32'd0);
    check("prio_fifo_pending", 32'(fifo.size()), 32'd1);
    wait_idle("prio", 100);

    // Reset while waiting for the grant: byte kept, ring index back to 0.
    ack_en = 1'b0;
    @(negedge Clk);
    fifo.push_back(8'hBB);
    wait_signal_req("rst_rx_req_reached", 20, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    #1;
    check("rst_rx_req_outputs", outs_all(), 32'd0);
    check("rst_rx_req_fifo", 32'(fifo.size()), 32'd1);
    Rst = 1'b0;
    ack_en = 1'b1;
    expect_wr(8'h00, 8'hBB);
    wait_idle("rst_rx", 100);

    // Reset while stalled in TX_SEND.
    stall_len = 30;
    @(negedge Clk);
    DMA_Tx_Start = 1'b1;
    wait_signal_req("rst_tx_send_reached", 20, 1'b1);
    @(negedge Clk);
    hold_chk_en = 1'b0;
    Rst = 1'b1;
    DMA_Tx_Start = 1'b0;
    @(negedge Clk);
    #1;
    check("rst_tx_send_outputs", outs_all(), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    hold_chk_en = 1'b1;

    // Seven RX bytes: ring address wraps 0,1,2,0,1,2,0.
    for (int i = 0; i < 7; i++)
      expect_wr(8'(i % 3), 8'(i + 1));
    @(negedge Clk);
    for (int i = 0; i < 7; i++)
      fifo.push_back(8'(i + 1));
    wait_idle("wrap", 400);
    check("rx_read_total", 32'(rx_read_cnt), 32'd12);

    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
    check("ready_total", 32'(ready_cnt), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
